// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset vector, NOP encoding, next-PC select
// codes and the IF/ID register payload.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned JT_W = 26;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC candidate generation and priority select (jr > j > branch > seq).
// Purely combinational; all outputs carry the _c suffix.
module pc_next_mux
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  if_id_pc4,
  input  logic             branch_taken,
  input  logic [IMM_W-1:0] branch_imm,
  input  logic             jump,
  input  logic [JT_W-1:0]  jump_target,
  input  logic             jump_reg,
  input  logic [XLEN-1:0]  jr_addr,
  output logic [XLEN-1:0]  seq_pc_c,
  output logic [XLEN-1:0]  next_pc_c,
  output logic             redirect_c,
  output pc_sel_e          sel_c
);

  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] j_pc;
  logic [XLEN-1:0] jr_pc;

  // Candidate targets, all modulo 2^32
  always_comb begin
    seq_pc_c = pc + XLEN'(4);
    br_pc    = if_id_pc4 + {{(XLEN-IMM_W-2){branch_imm[IMM_W-1]}}, branch_imm, 2'b00};
    j_pc     = {if_id_pc4[XLEN-1:XLEN-4], jump_target, 2'b00};
    jr_pc    = jr_addr & ~XLEN'(3);
  end

  always_comb begin
    sel_c      = SEL_SEQ;
    next_pc_c  = seq_pc_c;
    redirect_c = 1'b0;
    if (jump_reg) begin
      sel_c      = SEL_JR;
      next_pc_c  = jr_pc;
      redirect_c = 1'b1;
    end else if (jump) begin
      sel_c      = SEL_J;
      next_pc_c  = j_pc;
      redirect_c = 1'b1;
    end else if (branch_taken) begin
      sel_c      = SEL_BR;
      next_pc_c  = br_pc;
      redirect_c = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, and
// stall / redirect-flush control around the next-PC mux.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  instr_in,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [IMM_W-1:0] branch_imm,
  input  logic             jump,
  input  logic [JT_W-1:0]  jump_target,
  input  logic             jump_reg,
  input  logic [XLEN-1:0]  jr_addr,
  output logic [XLEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic             if_id_valid
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};
  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

  logic [XLEN-1:0] pc_q;
  if_id_t          if_id_q;
  logic [XLEN-1:0] seq_pc_c;
  logic [XLEN-1:0] next_pc_c;
  logic            redirect_c;
  pc_sel_e         sel_c;

  pc_next_mux u_pc_next_mux (
    .pc           (pc_q),
    .if_id_pc4    (if_id_q.pc4),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .jump_reg     (jump_reg),
    .jr_addr      (jr_addr),
    .seq_pc_c     (seq_pc_c),
    .next_pc_c    (next_pc_c),
    .redirect_c   (redirect_c),
    .sel_c        (sel_c)
  );

  // Stall freezes everything; a redirect squashes the shadow fetch unless it
  // is an architectural delay slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC_ALIGNED;
      if_id_q <= BUBBLE;
    end else if (!stall) begin
      pc_q <= next_pc_c;
      if (redirect_c && !DELAY_SLOT) begin
        if_id_q <= BUBBLE;
      end else begin
        if_id_q <= '{instr: instr_in, pc4: seq_pc_c, valid: 1'b1};
      end
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;

  // Select code is only informative outside the mux.
  logic unused_sel;
  assign unused_sel = ^sel_c;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit MIPS pipeline. Owns the program counter and drives the word address into the instruction memory. Computes the next PC from sequential, branch, jump and jump-register requests issued by decode. Captures the returned instruction into the IF/ID pipeline register, with stall and flush control.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- DELAY_SLOT, 0: 0 flushes the instruction fetched behind a taken redirect; 1 keeps it (MIPS delay slot).

Ports:
- clk  in  1  single clock; instruction memory samples `pc` on its negedge.
- rst  in  1  synchronous, active-high reset.
- pc  out  32  current fetch address, to instruction memory; bits [1:0] always 0.
- instr_in  in  32  instruction from memory, valid from negedge of the cycle `pc` was presented.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  decode: conditional branch resolved taken.
- branch_imm  in  16  decode: branch offset in words, signed.
- jump  in  1  decode: J/JAL.
- jump_target  in  26  decode: J-format target field.
- jump_reg  in  1  decode: JR/JALR.
- jr_addr  in  32  decode: register target; bits [1:0] ignored.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc4  out  32  IF/ID PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Redirect priority: jump_reg > jump > branch_taken > sequential.
  - Several redirect inputs may assert together; only the highest-priority one takes effect.
- Next-PC candidates, all mod 2^32:
  - seq = pc + 4
  - branch = if_id_pc4 + (sext(branch_imm) << 2)
  - jump = {if_id_pc4[31:28], jump_target, 2'b00}
  - jr = {jr_addr[31:2], 2'b00}
- Every posedge, first matching rule applies:
  - rst: pc = RESET_PC, if_id_instr = 32'h0 (NOP), if_id_pc4 = 0, if_id_valid = 0.
  - stall = 1: pc, if_id_instr, if_id_pc4, if_id_valid all hold. Redirect inputs are ignored; decode re-presents them after the stall.
  - Redirect taken:
    - pc = selected target.
    - DELAY_SLOT = 0: IF/ID loads a bubble (instr 0, valid 0, pc4 0).
    - DELAY_SLOT = 1: IF/ID loads instr_in / pc+4 / valid 1.
  - Otherwise: pc = seq; IF/ID loads instr_in, pc + 4, valid 1.
- Wrap-around: pc 32'hFFFF_FFFC sequentially becomes 32'h0000_0000. No exception is raised.
- Reset mid-stall or mid-redirect: reset wins; the pending redirect is lost.

## Timing
- Cycle n (posedge): pc updates.
  - Negedge of cycle n: memory latches instr_in for that pc.
  - Posedge n+1: IF/ID captures it.
- Fetch latency: one cycle from pc to if_id_instr.
- Redirect penalty:
  - Redirect asserted in cycle n takes effect at posedge n+1.
  - The target's instruction appears in IF/ID at posedge n+2.
  - With DELAY_SLOT = 0, exactly one bubble is inserted.
- First cycle after reset release: pc = RESET_PC, if_id_valid = 0. First valid IF/ID at the second posedge after reset deasserts.
- Next-PC selection is combinational from registered IF/ID state and decode inputs. No combinational path from instr_in to pc.

## Structure
- Shared package mips_pkg:
  - RESET_PC default
  - NOP_INSTR = 32'h0
  - next-PC select encoding (SEL_SEQ, SEL_BR, SEL_J, SEL_JR)
- Sub-module pc_next_mux: combinational; computes the four candidates and the priority select. fetch_stage holds only the registers and stall/flush logic.

## Test plan
- Reset then 4 free-running cycles, memory word k = 32'h1000_0000 + k:
  - pc = 0, 4, 8, 12.
  - if_id_valid = 0 in the first cycle, then instr 32'h1000_0000, …0001, …0002 with pc4 4, 8, 12.
- Branch with if_id_pc4 = 32'h10 and branch_imm = 16'hFFFC:
  - next pc = 32'h0000_0000.
  - DELAY_SLOT = 0: one cycle of if_id_valid = 0.
- All three redirects asserted together (jr_addr = 32'h0000_0203, jump_target = 26'h40, branch_imm = 5):
  - pc = 32'h0000_0200 (jr wins, low bits cleared).
- stall held 3 cycles while branch_taken = 1:
  - pc and IF/ID unchanged throughout.
  - Once stall drops with branch_taken still 1, the branch target is loaded.
- Wrap-around: force pc to 32'hFFFF_FFFC, no redirect.
  - next pc = 0.
  - if_id_pc4 = 0.
- rst asserted in the same cycle as jump:
  - pc = RESET_PC.
  - if_id_valid = 0.
- DELAY_SLOT = 1 with jump to 26'h100:
  - the fetched slot instruction stays valid in IF/ID.
  - pc = {if_id_pc4[31:28], 26'h100, 2'b00}.
